d_pipe_reg: RTL and testbench
=============================

// Module: d_pipe_reg
// PURPOSE
//  Parametrised D-register pipeline: DEPTH stages of WIDTH-bit edge-triggered
//  registers, each with a valid bit, and a valid/ready handshake at both ends.
//  - Bubbles collapse: a stage advances whenever the next stage is empty or is
//    itself advancing.
//  - Downstream stalls back-pressure upstream; flush drops all in-flight data.
//  - Used as the general retiming/buffering element between lab datapath blocks.
// PARAMETERS
//  WIDTH  8  data bits per stage (>=1)
//  DEPTH  4  number of register stages (>=1); also the maximum occupancy
// PORTS
//  clk        in   1                    rising-edge clock
//  rst        in   1                    async active-high reset
//  flush      in   1                    sync clear of all valid bits
//  in_valid   in   1                    upstream offers d
//  in_ready   out  1                    stage 0 can accept this cycle
//  d          in   WIDTH                input data
//  out_valid  out  1                    last stage holds valid data
//  out_ready  in   1                    downstream accepts q_out
//  q_out      out  WIDTH                last-stage data
//  occupancy  out  $clog2(DEPTH+1)      count of valid stages
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits=0, all stage data=0; hence
//    out_valid=0, q_out=0, occupancy=0, in_ready=0 while rst=1. Reset may
//    arrive mid-transfer; all held data is discarded, no partial state remains.
//  - Per stage i: adv[i] = v[i] & (i==DEPTH-1 ? out_ready : (~v[i+1] | adv[i+1])).
//    A stage loads from its predecessor (or from d for i=0) when it is empty or
//    advancing; stage data is held otherwise; data is never lost or duplicated.
//  - in_ready = ~v[0] | adv[0] (combinational from out_ready through the chain).
//  - Accept on in_valid & in_ready; emit on out_valid & out_ready.
//  - Latency: DEPTH cycles from accept to out_valid with an empty pipe and no
//    stalls.
//  - Throughput: 1 item/cycle sustained when out_ready=1.
//  - Full (occupancy=DEPTH) and out_ready=0: in_ready=0, all state holds.
//    When out_ready=1 with a full pipe, a simultaneous accept is allowed and
//    occupancy stays DEPTH.
//  - occupancy(next) = occupancy + accept - emit (registered, consistent with
//    the valid bits); it never exceeds DEPTH and never underflows.
//  - flush=1: at the next edge all valid bits=0 and occupancy=0. Data registers
//    are not cleared. in_ready is forced 0 during flush, so the input is dropped.
//    out_valid stays as registered that cycle, but an emit during a flush cycle
//    is still counted as a completed transfer.
//  - flush has priority over the handshake; rst has priority over everything.
//  - out_valid and q_out are driven directly from the last-stage registers (no
//    combinational path from d).
// STRUCTURE
//  - Shared package d_pipe_pkg: localparam helper function cnt_w(depth) =
//    $clog2(depth+1). Nothing else is shared.
//  - Sub-module d_pipe_stage: one WIDTH-bit data register plus valid bit.
//    Inputs: load, src_valid, src_data, flush. Output: its own valid and data.
//    Instantiated DEPTH times via generate.
//  - The top level computes the adv/in_ready chain and the occupancy counter.
// TESTING
//  1. Reset, then stream 0x01..0x08 with out_ready=1, WIDTH=8, DEPTH=4:
//     first out_valid 4 cycles after the first accept; q_out=0x01..0x08 in
//     order with one item per cycle.
//  2. Hold out_ready=0 and offer 6 items: exactly 4 are accepted; in_ready=0
//     after the 4th; occupancy=4. Release out_ready: the 4 items drain in
//     order, then the remaining 2 are accepted.
//  3. Bubble collapse: load A, idle 2 cycles, load B, with out_ready=0.
//     Within DEPTH cycles A sits in stage 3 and B in stage 2 (occupancy=2);
//     stage 0 stays empty and in_ready=1.
//  4. Pipe holding 3 items; flush=1 together with in_valid=1, d=0xAA:
//     next cycle occupancy=0 and out_valid=0; 0xAA never appears on q_out.
//  5. Assert rst mid-stream (asynchronously, between edges): out_valid, q_out
//     and occupancy go 0 immediately. After release, a fresh stream passes with
//     no stale data.
//  6. Full pipe with out_ready=1 and in_valid=1 for 10 cycles: occupancy holds
//     at 4 and accept/emit counts are equal. Repeat with DEPTH=1, WIDTH=1.

Source files
------------

// File: rtl/d_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d_pipe_pkg : shared sizing helper for the d_pipe_reg pipeline      |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package d_pipe_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d_pipe_stage : one WIDTH-bit data register with its valid bit      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module d_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Flush only clears the valid bit; the data word is left as is.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = src_valid;
      data_d  = src_data;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/d_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d_pipe_reg : DEPTH-stage valid/ready register pipeline with        |
// |              bubble collapse, flush and occupancy count            |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module d_pipe_reg
  import d_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          d,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          q_out,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data [DEPTH];
  logic             accept;
  logic             emit;
  logic [CW-1:0]    occ_d, occ_q;

  // Advance chain runs from the output back towards the input.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = v[i] & (~v[i+1] | adv[i+1]);
    end
    load = ~v | adv;
  end

  assign in_ready  = load[0] & ~flush & ~rst;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign out_valid = v[DEPTH-1];
  assign q_out     = data[DEPTH-1];
  assign occupancy = occ_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    if (i == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = d;
    end else begin : g_body
      assign src_valid = v[i-1];
      assign src_data  = data[i-1];
    end

    d_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .src_valid (src_valid),
      .src_data  (src_data),
      .flush     (flush),
      .valid     (v[i]),
      .data      (data[i])
    );
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + CW'(accept) - CW'(emit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_d_pipe_reg : directed + random checks of d_pipe_reg (4x8, 1x1)  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_d_pipe_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] d = '0;
  logic       out_ready = 1'b0;

  logic       rdy4, v4, rdy1, v1, q1;
  logic [7:0] q4;
  logic [2:0] occ4;
  logic [0:0] occ1;

  always #5 clk = ~clk;

  d_pipe_reg #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .d(d), .out_valid(v4), .out_ready(out_ready), .q_out(q4), .occupancy(occ4)
  );

  d_pipe_reg #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .d(d[0]), .out_valid(v1), .out_ready(out_ready), .q_out(q1), .occupancy(occ1)
  );

  // Which instance is under check.
  bit         phase = 1'b0;
  int         mdepth = 4;
  logic       obs_ready, obs_valid;
  logic [7:0] obs_q;
  logic [2:0] obs_occ;
  assign obs_ready = phase ? rdy1 : rdy4;
  assign obs_valid = phase ? v1 : v4;
  assign obs_q     = phase ? {7'b0, q1} : q4;
  assign obs_occ   = phase ? {2'b0, occ1} : occ4;

  // Reference model: in-flight items in order, each with its stage position.
  typedef struct {
    logic [7:0] data;
    int         pos;
  } item_t;
  item_t mq[$];
  int    np[$];
  bit    m_emit;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_oacc   = 0;
  int n_oemit  = 0;
  int first_acc, first_out;
  bit last_acc;
  bit seen_aa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each item moves one stage forward unless blocked by the item ahead.
  function automatic void m_plan(input bit ordy);
    int lim;
    np     = {};
    m_emit = 1'b0;
    lim    = mdepth;
    foreach (mq[k]) begin
      int n;
      if (k == 0 && mq[k].pos == mdepth - 1) begin
        if (ordy) begin
          n      = mdepth;
          m_emit = 1'b1;
        end else begin
          n = mq[k].pos;
        end
      end else begin
        n = mq[k].pos + 1;
        if (n > lim - 1) n = lim - 1;
      end
      np.push_back(n);
      lim = n;
    end
  endfunction

  task automatic cycle(input bit fl, input bit iv, input logic [7:0] dv, input bit ordy);
    bit         exp_ready, exp_valid, acc;
    logic [7:0] din;
    @(negedge clk);
    flush = fl; in_valid = iv; d = dv; out_ready = ordy;
    #1;
    m_plan(ordy);
    exp_ready = !fl && (mq.size() == 0 || np[np.size()-1] >= 1);
    exp_valid = mq.size() > 0 && mq[0].pos == mdepth - 1;
    chk("in_ready", 32'(obs_ready), 32'(exp_ready));
    chk("out_valid", 32'(obs_valid), 32'(exp_valid));
    if (exp_valid) chk("q_out", 32'(obs_q), 32'(mq[0].data));
    chk("occupancy", 32'(obs_occ), 32'(mq.size()));
    if (iv && obs_ready) begin
      n_oacc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (obs_valid && ordy) n_oemit++;
    if (obs_valid && first_out < 0) first_out = cyc;
    if (obs_valid && obs_q == 8'hAA) seen_aa = 1'b1;
    acc      = iv && exp_ready;
    last_acc = acc;
    din      = phase ? {7'b0, dv[0]} : dv;
    @(posedge clk);
    cyc++;
    if (fl) begin
      mq = {};
    end else begin
      foreach (mq[k]) mq[k].pos = np[k];
      if (m_emit) void'(mq.pop_front());
      if (acc) mq.push_back('{data: din, pos: 0});
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, ordy);
  endtask

  task automatic reset_check();
    chk("rst_out_valid", 32'(obs_valid), 32'd0);
    chk("rst_q_out", 32'(obs_q), 32'd0);
    chk("rst_occupancy", 32'(obs_occ), 32'd0);
    chk("rst_in_ready", 32'(obs_ready), 32'd0);
    mq = {};
    flush = 1'b0; in_valid = 1'b0; d = '0;
  endtask

  task automatic t_stream();
    first_acc = -1;
    first_out = -1;
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 8'(i), 1'b1);
    idle(mdepth + 2, 1'b1);
    chk("latency", 32'(first_out - first_acc), 32'(mdepth));
  endtask

  task automatic t_full();
    int a0, e0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    a0 = n_oacc;
    e0 = n_oemit;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(8'h50 + i), 1'b1);
    chk("full_acc_eq_emit", 32'(n_oacc - a0), 32'(n_oemit - e0));
    chk("full_acc_count", 32'(n_oacc - a0), 32'd10);
    idle(mdepth + 1, 1'b1);
  endtask

  task automatic t_random(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
            $urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic [7:0] pend[$];
    int         a0;

    // Power-on reset
    #3;
    reset_check();
    @(negedge clk);
    rst = 1'b0;

    t_stream();

    // Back-pressure: six offers against a stalled output
    pend = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    a0   = n_oacc;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, pend.size() > 0, (pend.size() > 0) ? pend[0] : 8'h00, 1'b0);
      if (last_acc) void'(pend.pop_front());
    end
    chk("stall_accepted", 32'(n_oacc - a0), 32'd4);
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, pend.size() > 0, (pend.size() > 0) ? pend[0] : 8'h00, 1'b1);
      if (last_acc) void'(pend.pop_front());
    end
    chk("stall_all_taken", 32'(pend.size()), 32'd0);
    idle(5, 1'b1);

    // Bubble collapse
    cycle(1'b0, 1'b1, 8'hA1, 1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 8'hB2, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Flush with a simultaneous offer of 0xAA
    seen_aa = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    idle(6, 1'b1);
    chk("flush_no_aa", 32'(seen_aa), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
    #3;
    rst = 1'b1;
    #1;
    reset_check();
    @(negedge clk);
    rst = 1'b0;
    t_stream();

    t_full();
    t_random(300);

    // Switch to the 1-deep, 1-bit instance
    @(negedge clk);
    rst = 1'b1;
    phase = 1'b1;
    mdepth = 1;
    #1;
    reset_check();
    @(negedge clk);
    rst = 1'b0;
    t_stream();
    t_full();
    t_random(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
